// File: rtl/gpio_cfg_pkg.sv
// Shared constants for the per-pad GPIO configuration holder: field bit map,
// FSM encoding, bit-counter sizing and the reference default word.
package gpio_cfg_pkg;

  localparam int CFG_WIDTH = 13;

  localparam int CFG_MGMT_EN    = 0;
  localparam int CFG_OUTENB     = 1;
  localparam int CFG_HOLDOVER   = 2;
  localparam int CFG_INP_DIS    = 3;
  localparam int CFG_IB_MODE    = 4;
  localparam int CFG_ANA_EN     = 5;
  localparam int CFG_ANA_SEL    = 6;
  localparam int CFG_ANA_POL    = 7;
  localparam int CFG_SLOW_SEL   = 8;
  localparam int CFG_VTRIP_SEL  = 9;
  localparam int CFG_DM_LSB     = 10;
  localparam int CFG_DM_MSB     = 12;

  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX  = 4'd15;
  localparam logic [CNT_W-1:0]  CNT_FULL = 4'(CFG_WIDTH);

  localparam logic [CFG_WIDTH-1:0] CFG_RESET_DEFAULT = 13'h0402;

  typedef enum logic {
    CFG_DEFAULT    = 1'b0,
    CFG_PROGRAMMED = 1'b1
  } cfg_state_e;

  // Bit counter holds at its ceiling so long shift bursts never wrap back to 13.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/gpio_cfg_shreg.sv
// Daisy-chain shift register with a saturating count of bits shifted since the
// last load/reload; both preset from the pad default word on reset or reload.
module gpio_cfg_shreg
  import gpio_cfg_pkg::*;
#(
  parameter int WIDTH = CFG_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] defaults_i,
  input  logic             preset_i,
  input  logic             shift_en_i,
  input  logic             data_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] shreg_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (preset_i) begin
      shreg_d = defaults_i;
      cnt_d   = '0;
    end else begin
      if (shift_en_i) begin
        shreg_d = {shreg_q[WIDTH-2:0], data_i};
      end
      // A shift coinciding with a load is not counted toward the next word.
      if (cnt_clr_i) begin
        cnt_d = '0;
      end else if (shift_en_i) begin
        cnt_d = cnt_sat_inc(cnt_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= defaults_i;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign shreg_o = shreg_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/gpio_config_shift_ctrl.sv
// Per-pad GPIO config holder: serial shift chain feeding a live config register,
// preset from mask defaults; load updates outputs one edge after serial_load.
module gpio_config_shift_ctrl
  import gpio_cfg_pkg::*;
#(
  parameter int WIDTH       = CFG_WIDTH,
  parameter bit STRICT_LOAD = 1'b0
) (
  input  logic             serial_clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gpio_defaults,
  input  logic             defaults_reload,
  input  logic             serial_shift_en,
  input  logic             serial_data_in,
  input  logic             serial_load,
  output logic             serial_data_out,
  output logic             mgmt_ena,
  output logic             gpio_outenb,
  output logic             gpio_holdover,
  output logic             gpio_inp_dis,
  output logic             gpio_ib_mode_sel,
  output logic             gpio_ana_en,
  output logic             gpio_ana_sel,
  output logic             gpio_ana_pol,
  output logic             gpio_slow_sel,
  output logic             gpio_vtrip_sel,
  output logic [2:0]       gpio_dm,
  output logic             cfg_programmed,
  output logic             load_err
);

  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] cfg_q, cfg_d;
  logic             load_err_q, load_err_d;
  cfg_state_e       state_q, state_d;
  logic             load_ok;

  gpio_cfg_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk_i      (serial_clock),
    .rst_ni     (resetn),
    .defaults_i (gpio_defaults),
    .preset_i   (defaults_reload),
    .shift_en_i (serial_shift_en),
    .data_i     (serial_data_in),
    .cnt_clr_i  (serial_load),
    .shreg_o    (shreg_q),
    .cnt_o      (cnt_q)
  );

  // Counter is compared before any same-cycle shift lands.
  assign load_ok = serial_load && !defaults_reload &&
                   (!STRICT_LOAD || (cnt_q == CNT_FULL));

  always_comb begin
    cfg_d      = cfg_q;
    load_err_d = load_err_q;
    if (defaults_reload) begin
      cfg_d = gpio_defaults;
    end else if (serial_load) begin
      if (load_ok) begin
        cfg_d = shreg_q;
      end else begin
        load_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge serial_clock) begin
    if (!resetn) begin
      cfg_q      <= gpio_defaults;
      load_err_q <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      load_err_q <= load_err_d;
    end
  end

  always_ff @(posedge serial_clock) begin
    if (!resetn) begin
      state_q <= CFG_DEFAULT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG_DEFAULT:    if (load_ok)         state_d = CFG_PROGRAMMED;
      CFG_PROGRAMMED: if (defaults_reload) state_d = CFG_DEFAULT;
      default:                             state_d = CFG_DEFAULT;
    endcase
  end

  always_comb begin
    cfg_programmed = (state_q == CFG_PROGRAMMED);
  end

  assign serial_data_out  = shreg_q[WIDTH-1];
  assign load_err         = load_err_q;
  assign mgmt_ena         = cfg_q[CFG_MGMT_EN];
  assign gpio_outenb      = cfg_q[CFG_OUTENB];
  assign gpio_holdover    = cfg_q[CFG_HOLDOVER];
  assign gpio_inp_dis     = cfg_q[CFG_INP_DIS];
  assign gpio_ib_mode_sel = cfg_q[CFG_IB_MODE];
  assign gpio_ana_en      = cfg_q[CFG_ANA_EN];
  assign gpio_ana_sel     = cfg_q[CFG_ANA_SEL];
  assign gpio_ana_pol     = cfg_q[CFG_ANA_POL];
  assign gpio_slow_sel    = cfg_q[CFG_SLOW_SEL];
  assign gpio_vtrip_sel   = cfg_q[CFG_VTRIP_SEL];
  assign gpio_dm          = cfg_q[CFG_DM_MSB:CFG_DM_LSB];

endmodule

// File: tb/tb_gpio_config_shift_ctrl.sv
// Two chained relaxed instances (a feeds b) plus one strict instance s, all
// sharing control inputs, checked against hand vectors and a behavioural model.
module tb_gpio_config_shift_ctrl;
  import gpio_cfg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, reload, shift, din, load;
  logic [12:0] defaults;

  wire        sdo_a, sdo_b, sdo_s, prog_a, prog_b, prog_s, err_a, err_b, err_s;
  wire [12:0] cfg_a, cfg_b, cfg_s;

  gpio_config_shift_ctrl #(.WIDTH(13), .STRICT_LOAD(1'b0)) u_a (
    .serial_clock(clk), .resetn(resetn), .gpio_defaults(defaults),
    .defaults_reload(reload), .serial_shift_en(shift), .serial_data_in(din),
    .serial_load(load), .serial_data_out(sdo_a),
    .mgmt_ena(cfg_a[0]), .gpio_outenb(cfg_a[1]), .gpio_holdover(cfg_a[2]),
    .gpio_inp_dis(cfg_a[3]), .gpio_ib_mode_sel(cfg_a[4]), .gpio_ana_en(cfg_a[5]),
    .gpio_ana_sel(cfg_a[6]), .gpio_ana_pol(cfg_a[7]), .gpio_slow_sel(cfg_a[8]),
    .gpio_vtrip_sel(cfg_a[9]), .gpio_dm(cfg_a[12:10]),
    .cfg_programmed(prog_a), .load_err(err_a));

  gpio_config_shift_ctrl #(.WIDTH(13), .STRICT_LOAD(1'b0)) u_b (
    .serial_clock(clk), .resetn(resetn), .gpio_defaults(defaults),
    .defaults_reload(reload), .serial_shift_en(shift), .serial_data_in(sdo_a),
    .serial_load(load), .serial_data_out(sdo_b),
    .mgmt_ena(cfg_b[0]), .gpio_outenb(cfg_b[1]), .gpio_holdover(cfg_b[2]),
    .gpio_inp_dis(cfg_b[3]), .gpio_ib_mode_sel(cfg_b[4]), .gpio_ana_en(cfg_b[5]),
    .gpio_ana_sel(cfg_b[6]), .gpio_ana_pol(cfg_b[7]), .gpio_slow_sel(cfg_b[8]),
    .gpio_vtrip_sel(cfg_b[9]), .gpio_dm(cfg_b[12:10]),
    .cfg_programmed(prog_b), .load_err(err_b));

  gpio_config_shift_ctrl #(.WIDTH(13), .STRICT_LOAD(1'b1)) u_s (
    .serial_clock(clk), .resetn(resetn), .gpio_defaults(defaults),
    .defaults_reload(reload), .serial_shift_en(shift), .serial_data_in(din),
    .serial_load(load), .serial_data_out(sdo_s),
    .mgmt_ena(cfg_s[0]), .gpio_outenb(cfg_s[1]), .gpio_holdover(cfg_s[2]),
    .gpio_inp_dis(cfg_s[3]), .gpio_ib_mode_sel(cfg_s[4]), .gpio_ana_en(cfg_s[5]),
    .gpio_ana_sel(cfg_s[6]), .gpio_ana_pol(cfg_s[7]), .gpio_slow_sel(cfg_s[8]),
    .gpio_vtrip_sel(cfg_s[9]), .gpio_dm(cfg_s[12:10]),
    .cfg_programmed(prog_s), .load_err(err_s));

  logic [12:0] cfg_v [3];
  logic        prog_v[3], err_v[3], sdo_v[3];
  always_comb begin
    cfg_v[0] = cfg_a;   cfg_v[1] = cfg_b;   cfg_v[2] = cfg_s;
    prog_v[0] = prog_a; prog_v[1] = prog_b; prog_v[2] = prog_s;
    err_v[0] = err_a;   err_v[1] = err_b;   err_v[2] = err_s;
    sdo_v[0] = sdo_a;   sdo_v[1] = sdo_b;   sdo_v[2] = sdo_s;
  end

  // Reference model: each pad holds a chain word, a live word, a bit tally,
  // a programmed flag and an error flag; index 2 is the strict pad.
  int          m_sh[3], m_cfg[3], m_cnt[3];
  bit          m_prog[3], m_err[3];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  task automatic model_step();
    int old_sh[3];
    int d[3];
    for (int k = 0; k < 3; k++) old_sh[k] = m_sh[k];
    d[0] = int'(din);
    d[1] = (old_sh[0] / 4096) % 2;
    d[2] = int'(din);
    for (int k = 0; k < 3; k++) begin
      if (!resetn || reload) begin
        m_sh[k]   = int'(defaults);
        m_cfg[k]  = int'(defaults);
        m_cnt[k]  = 0;
        m_prog[k] = 1'b0;
        if (!resetn) m_err[k] = 1'b0;
      end else begin
        if (load) begin
          if (k != 2 || m_cnt[k] == 13) begin
            m_cfg[k]  = old_sh[k];
            m_prog[k] = 1'b1;
          end else begin
            m_err[k] = 1'b1;
          end
          m_cnt[k] = 0;
        end else if (shift) begin
          m_cnt[k] = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
        end
        if (shift) m_sh[k] = (old_sh[k] * 2 + d[k]) % 8192;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("model_cfg",  k, int'(cfg_v[k]),  m_cfg[k]);
      chk("model_prog", k, int'(prog_v[k]), int'(m_prog[k]));
      chk("model_err",  k, int'(err_v[k]),  int'(m_err[k]));
      chk("model_sdo",  k, int'(sdo_v[k]),  (m_sh[k] / 4096) % 2);
    end
    resetn = 1'b1; reload = 1'b0; shift = 1'b0; load = 1'b0; din = 1'b0;
  endtask

  typedef enum int {OP_RST, OP_SHIFT, OP_LOAD, OP_SHLD, OP_RLD_LD} op_e;
  typedef struct {
    op_e         op;
    int          n;
    logic [12:0] word;
    logic [12:0] exp_cfg_a;
    logic [12:0] exp_cfg_s;
    bit          exp_prog_s;
    bit          exp_err_s;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  initial begin
    logic [12:0] w;
    logic [25:0] w26;
    int          emitted;

    resetn = 1'b0; reload = 1'b0; shift = 1'b0; load = 1'b0; din = 1'b0;
    defaults = CFG_RESET_DEFAULT;

    tbl[0]  = '{OP_RST,    1,  13'h0000, 13'h0402, 13'h0402, 1'b0, 1'b0};
    tbl[1]  = '{OP_SHIFT,  13, 13'h1803, 13'h0402, 13'h0402, 1'b0, 1'b0};
    tbl[2]  = '{OP_LOAD,   1,  13'h0000, 13'h1803, 13'h1803, 1'b1, 1'b0};
    tbl[3]  = '{OP_SHIFT,  12, 13'h0555, 13'h1803, 13'h1803, 1'b1, 1'b0};
    tbl[4]  = '{OP_LOAD,   1,  13'h0000, 13'h1555, 13'h1803, 1'b1, 1'b1};
    tbl[5]  = '{OP_SHIFT,  13, 13'h0AAA, 13'h1555, 13'h1803, 1'b1, 1'b1};
    tbl[6]  = '{OP_SHLD,   1,  13'h0001, 13'h0AAA, 13'h0AAA, 1'b1, 1'b1};
    tbl[7]  = '{OP_LOAD,   1,  13'h0000, 13'h1555, 13'h0AAA, 1'b1, 1'b1};
    tbl[8]  = '{OP_RLD_LD, 1,  13'h0000, 13'h0402, 13'h0402, 1'b0, 1'b1};
    tbl[9]  = '{OP_SHIFT,  7,  13'h007F, 13'h0402, 13'h0402, 1'b0, 1'b1};
    tbl[10] = '{OP_RST,    1,  13'h0000, 13'h0402, 13'h0402, 1'b0, 1'b0};
    tbl[11] = '{OP_SHIFT,  13, 13'h1803, 13'h0402, 13'h0402, 1'b0, 1'b0};
    tbl[12] = '{OP_LOAD,   1,  13'h0000, 13'h1803, 13'h1803, 1'b1, 1'b0};

    @(negedge clk);
    for (int v = 0; v < NV; v++) begin
      w = tbl[v].word;
      for (int b = 0; b < tbl[v].n; b++) begin
        case (tbl[v].op)
          OP_RST:    resetn = 1'b0;
          OP_SHIFT:  begin shift = 1'b1; din = w[tbl[v].n-1-b]; end
          OP_LOAD:   load = 1'b1;
          OP_SHLD:   begin shift = 1'b1; load = 1'b1; din = w[0]; end
          OP_RLD_LD: begin reload = 1'b1; load = 1'b1; end
          default:   ;
        endcase
        step();
      end
      chk("vec_cfg_a",  v, int'(cfg_a),  int'(tbl[v].exp_cfg_a));
      chk("vec_cfg_s",  v, int'(cfg_s),  int'(tbl[v].exp_cfg_s));
      chk("vec_prog_s", v, int'(prog_s), int'(tbl[v].exp_prog_s));
      chk("vec_err_s",  v, int'(err_s),  int'(tbl[v].exp_err_s));
    end

    // Two-pad chain: first word travels to the far pad, near pad emits its preset.
    resetn = 1'b0;
    step();
    chk("rst_dm",     0, int'(cfg_a[12:10]), 1);
    chk("rst_outenb", 0, int'(cfg_a[1]),     1);
    w26 = {13'h0001, 13'h1FFF};
    emitted = 0;
    for (int i = 0; i < 26; i++) begin
      if (i < 13) emitted = emitted * 2 + int'(sdo_a);
      shift = 1'b1;
      din = w26[25-i];
      step();
    end
    load = 1'b1;
    step();
    chk("chain_emit",  0, emitted,       13'h0402);
    chk("chain_far",   1, int'(cfg_b),   13'h0001);
    chk("chain_near",  0, int'(cfg_a),   13'h1FFF);
    chk("chain_prog",  1, int'(prog_b),  1);

    // Default word is ignored until a reload samples it.
    defaults = 13'h1ABC;
    step();
    chk("dflt_static", 0, int'(cfg_a), 13'h1FFF);
    reload = 1'b1;
    step();
    chk("dflt_reload", 0, int'(cfg_a),  13'h1ABC);
    chk("dflt_prog",   0, int'(prog_a), 0);

    for (int c = 0; c < 600; c++) begin
      resetn = ($urandom_range(0, 59) != 0);
      reload = ($urandom_range(0, 39) == 0);
      shift  = ($urandom_range(0, 3) != 0);
      din    = 1'($urandom_range(0, 1));
      load   = ($urandom_range(0, 13) == 0);
      if ($urandom_range(0, 19) == 0) defaults = 13'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
